// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Contents:
//   - MEM_DEPTH_DEF : default instruction-memory size in bytes
//   - state_t and St* : loader FSM state encoding
//   - ERR_NONE / ERR_LEN / ERR_CSUM : err_code values
package imem_loader_pkg;

    localparam int unsigned MEM_DEPTH_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StCheck = 3'd2;
    localparam state_t StDrain = 3'd3;
    localparam state_t StRun   = 3'd4;
    localparam state_t StErr   = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write bus of the loader.
// Signals:
//   in_valid / in_data / in_ready : host byte handshake (transfer = valid && ready)
//   mem_we / mem_addr / mem_wdata : byte-wide instruction-memory write port
// Modports:
//   slave  : the loader (consumes the stream, drives the memory bus)
//   master : the host / memory side
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader_csum.sv
// 8-bit modular byte accumulator used to verify the image checksum.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : zero the running sum
//   add_i     : add byte_i into the sum (mod 256)
//   byte_i    : byte to accumulate
//   cmp_i     : candidate checksum byte
//   match_o   : cmp_i equals the current sum
module imem_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] byte_i,
    input  logic [7:0] cmp_i,
    output logic       match_o
);
    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'd0;
        end else if (add_i) begin
            sum_d = sum_q + byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_o = (sum_q == cmp_i);
endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Takes a length byte, L payload bytes and
// (optionally) a checksum byte, writes the payload into the instruction memory
// from address 0 and holds the processor until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require and verify a
// trailing checksum byte (sum of payload mod 256).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   restart   : return to idle from any state
//   bus       : imem_loader_if.slave (host byte stream + memory write bus)
//   cpu_hold  : keep the processor held (high in every state but RUN)
//   done      : image loaded, processor released
//   err       : load failed
//   err_code  : ERR_NONE / ERR_LEN / ERR_CSUM
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic ready;
    logic xfer;
    logic len_bad;

    // rst is included so the host never sees a transfer that reset discards.
    assign ready = ((state_q == StIdle) || (state_q == StLoad) || (state_q == StCheck))
                   && !restart && !rst;
    assign xfer  = bus.in_valid && ready;

    assign len_bad = (bus.in_data == 8'd0) || (32'(bus.in_data) > MEM_DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic csum_clr;
    logic csum_add;
    logic csum_match;

    imem_loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (csum_clr),
        .add_i   (csum_add),
        .byte_i  (bus.in_data),
        .cmp_i   (bus.in_data),
        .match_o (csum_match)
    );
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        err_code_d  = err_code_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_clr    = 1'b0;
        csum_add    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (len_bad) begin
                        state_d    = StErr;
                        err_code_d = ERR_LEN;
                    end else begin
                        // Store L-1 so the final-byte test is a plain equality.
                        last_d  = ADDR_W'(bus.in_data - 8'd1);
                        addr_d  = '0;
                        state_d = StLoad;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_clr = 1'b1;
`endif
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_add    = 1'b1;
`endif
                    if (addr_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        // One extra cycle so the last write lands before release.
                        state_d = StDrain;
`endif
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            StCheck: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    if (csum_match) begin
                        state_d = StRun;
                    end else begin
                        state_d    = StErr;
                        err_code_d = ERR_CSUM;
                    end
                end
`else
                state_d = StRun;
`endif
            end
            StDrain: state_d = StRun;
            StRun:   state_d = StRun;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase

        if (restart) begin
            state_d    = StIdle;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_q      <= '0;
            err_code_q  <= ERR_NONE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            err_code_q  <= err_code_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign done     = (state_q == StRun);
    assign err      = (state_q == StErr);
    assign cpu_hold = (state_q != StRun);
    assign err_code = err_code_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed cases plus randomized frames,
// checked against a frame-level reference (expected writes, outcome, release cycle).
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic       clk;
    logic       rst;
    logic       restart;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    imem_loader_if #(.ADDR_W(5)) bus ();

    imem_loader #(
        .MEM_DEPTH (32),
        .ADDR_W    (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] frame_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle: a write must appear exactly when one is due, with the queued addr/data.
    logic due;
    always @(negedge clk) begin
        due = 1'b0;
        if (wq.size() > 0) due = (wq[0].cyc == cyc);
        check("mem_we", 32'(bus.mem_we), 32'(due));
        if (due) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(wq[0].addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(wq[0].data));
            void'(wq.pop_front());
        end
    end

    task automatic push_wr(input int c, input int a, input logic [7:0] d);
        wr_t w;
        w.cyc  = c;
        w.addr = 5'(a);
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic check_status(input bit exp_done, input bit exp_err, input logic [1:0] exp_code);
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(exp_err));
        check("err_code", 32'(err_code), 32'(exp_code));
        check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    endtask

    // Called and returns at posedge+1. Holds the byte until accepted (bounded).
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc, output bit ok);
        ok  = 1'b0;
        acc = 0;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            check("accept_timeout", 32'd0, 32'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return $urandom_range(0, 2);
        return 0;
    endfunction

    // Sends frame_q and checks writes and outcome derived from the frame contents.
    task automatic run_frame(input int gap_mode);
        int         len;
        int         t;
        bit         ok;
        logic [7:0] s;
        len = int'(frame_q[0]);
        s   = 8'd0;
        send_byte(frame_q[0], pick_gap(gap_mode), t, ok);
        if (!ok) return;
        if (len == 0 || len > 32) begin
            @(negedge clk);
            check_status(1'b0, 1'b1, ERR_LEN);
            check("ready_in_err", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int i = 1; i <= len; i++) begin
                send_byte(frame_q[i], pick_gap(gap_mode), t, ok);
                if (!ok) return;
                push_wr(t + 1, i - 1, frame_q[i]);
                s = s + frame_q[i];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(frame_q[len + 1], pick_gap(gap_mode), t, ok);
            if (!ok) return;
            @(negedge clk);
            if (frame_q[len + 1] == s) check_status(1'b1, 1'b0, ERR_NONE);
            else check_status(1'b0, 1'b1, ERR_CSUM);
            check("ready_after_frame", 32'(bus.in_ready), 32'd0);
`else
            // Release comes two cycles after the final payload byte.
            @(negedge clk);
            check_status(1'b0, 1'b0, ERR_NONE);
            check("ready_drain", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check_status(1'b1, 1'b0, ERR_NONE);
`endif
            @(posedge clk); #1;
        end
        check("writes_pending", 32'(wq.size()), 32'd0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("ready_in_restart", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        restart = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_status(1'b0, 1'b0, ERR_NONE);
        check("ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic set_frame4(input logic [7:0] c);
        frame_q.delete();
        frame_q.push_back(8'h04);
        frame_q.push_back(8'h8C);
        frame_q.push_back(8'h22);
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h04);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(c);
`else
        if (c == 8'h00) frame_q.push_back(c);
`endif
    endtask

    initial begin
        int         t;
        bit         ok;
        int         len;
        int         r;
        logic [7:0] s;
        logic [7:0] b;

        rst          = 1'b1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (2) @(posedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check_status(1'b0, 1'b0, ERR_NONE);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Good 4-byte image, then restart from RUN.
        set_frame4(8'hB2);
        run_frame(0);
        do_restart();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: writes still happen, then error.
        set_frame4(8'hB3);
        run_frame(0);
        do_restart();
`endif

        // Bad lengths 0 and 33.
        frame_q.delete();
        frame_q.push_back(8'h00);
        run_frame(0);
        do_restart();
        frame_q.delete();
        frame_q.push_back(8'h21);
        run_frame(0);
        do_restart();

        // Full-depth image 00..1F.
        frame_q.delete();
        frame_q.push_back(8'h20);
        for (int i = 0; i < 32; i++) frame_q.push_back(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'hF0);
`endif
        run_frame(0);
        do_restart();

        // Reset in the cycle after the second payload byte.
        send_byte(8'h04, 0, t, ok);
        send_byte(8'h11, 0, t, ok);
        if (ok) push_wr(t + 1, 0, 8'h11);
        send_byte(8'h22, 0, t, ok);
        if (ok) push_wr(t + 1, 1, 8'h22);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        @(negedge clk);
        check("ready_in_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("we_after_rst", 32'(bus.mem_we), 32'd0);
        check_status(1'b0, 1'b0, ERR_NONE);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        frame_q.delete();
        frame_q.push_back(8'h01);
        frame_q.push_back(8'hAA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'hAA);
`endif
        run_frame(0);
        do_restart();

        // Gapped payload, restart in RUN.
        set_frame4(8'hB2);
        run_frame(1);
        do_restart();

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            frame_q.delete();
            if (r == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
                frame_q.push_back(8'(len));
            end else begin
                len = $urandom_range(1, 32);
                frame_q.push_back(8'(len));
                s = 8'd0;
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom);
                    frame_q.push_back(b);
                    s = s + b;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (r == 1) frame_q.push_back(s + 8'($urandom_range(1, 255)));
                else frame_q.push_back(s);
`endif
            end
            run_frame($urandom_range(0, 2));
            do_restart();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader sitting directly upstream of the single-cycle MIPS-lite processor. Accepts a byte stream (length header, payload, optional checksum) over a valid/ready handshake, writes each payload byte into the processor's byte-wide instruction memory starting at address 0, and holds the processor until the image is complete and verified. Replaces file-based instruction-memory initialisation for hardware bring-up.

## Interface
- MEM_DEPTH, 32, instruction-memory size in bytes; legal lengths are 1..MEM_DEPTH
- ADDR_W, 5, memory address width; log2(MEM_DEPTH)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader can accept a byte this cycle
- restart  in  1  return to IDLE from any state
- mem_we  out  1  instruction-memory byte write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- cpu_hold  out  1  high keeps processor PC at 0 / clock-gated
- done  out  1  image loaded, processor released
- err  out  1  load failed
- err_code  out  2  00 none, 01 bad length, 10 checksum mismatch

## Operation
- Transfer = in_valid && in_ready at rising edge. in_ready = state in {IDLE, LOAD, CHECK} && !restart; combinational from state.
- States: IDLE, LOAD, CHECK, DRAIN, RUN, ERR.
- IDLE: accepted byte is length L. L==0 or L>MEM_DEPTH -> ERR, err_code 01. Else latch L, addr=0, sum=0 -> LOAD.
- LOAD: each accepted byte b -> registered write (mem_we=1, mem_addr=addr, mem_wdata=b) next cycle; sum=(sum+b) mod 256; addr+1. On byte with addr==L-1 -> CHECK (macro on) or DRAIN (macro off). Address never wraps; L bounds it.
- CHECK: accepted byte c. c==sum -> RUN; else ERR, err_code 10.
- DRAIN: one cycle, no transfer, -> RUN.
- RUN: cpu_hold=0, done=1. Stays until restart.
- ERR: err=1, cpu_hold=1. Stays until restart.
- restart (any state): -> IDLE next edge, err_code cleared, no byte accepted that cycle. Pending write from previous cycle still completes.
- Memory contents are never cleared by the loader.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, err 0, err_code 00, sum 0. in_ready 0 while rst high.
- Write latency: byte accepted cycle t -> mem_we high in cycle t+1 only.
- Release: cpu_hold falls no earlier than the cycle after the final mem_we. Macro off: last payload byte at t -> DRAIN t+1 (final write) -> RUN t+2. Macro on: checksum accepted at t_c -> RUN at t_c+1.
- done, err, cpu_hold are pure state decodes of registered state: change one cycle after the deciding transfer.
- rst mid-load: next cycle IDLE, mem_we 0 (pending write dropped), cpu_hold 1.
- rst and restart together: rst wins (same result).
- Back-to-back bytes accepted every cycle; gaps in in_valid only stall.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: CHECK state present; trailing checksum byte required and compared; err_code 10 reachable.
- Undefined: no checksum byte; LOAD -> DRAIN -> RUN; sum logic removed; err_code 10 unreachable.

## Structure
- Package imem_loader_pkg: state enum, err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM), default MEM_DEPTH.
- Sub-module imem_loader_csum: 8-bit modular accumulator with clear, add(b), and match(c) output; instantiated only under IMEM_LOADER_CHECKSUM_EN.

## Test plan
- Macro on; bytes 04, 8C, 22, 00, 04, B2 -> writes addr 0..3 = 8C,22,00,04; done=1, cpu_hold=0 one cycle after B2 accepted.
- Same stream with checksum B3 -> four writes still occur; err=1, err_code=10, cpu_hold=1; restart -> IDLE, err=0.
- Length 00, then after restart length 21 (33) -> err_code 01 each time, no mem_we.
- Length 20 (32), payload 00..1F, checksum F0 -> writes addr 0..31, no wrap, done=1; macro off: RUN exactly two cycles after byte 1F.
- rst asserted cycle after second payload byte -> mem_we low next cycle, state IDLE; fresh 01, AA, AA stream loads addr 0 = AA, done.
- in_valid toggled every other cycle during payload, restart pulsed in RUN -> correct writes; restart returns cpu_hold=1, done=0.
